// File: rtl/mux_select_sequencer.sv
// Control stage for mux_generic_1bit: captures a parallel word, then steps the
// select LSB-first with a per-step settle delay and a valid/ready/last bit handshake.
module mux_select_sequencer #(
  parameter int INS    = 4,
  parameter int SETTLE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INS-1:0]         in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [INS-1:0]         w_out,
  output logic [$clog2(INS)-1:0] s_out,
  output logic                   bit_valid,
  output logic                   bit_last,
  input  logic                   bit_ready
);

  localparam int SW = $clog2(INS);
  localparam logic [SW-1:0] S_LAST   = SW'(INS - 1);
  localparam logic [3:0]    CNT_DONE = 4'(SETTLE);

  typedef enum logic {IDLE, RUN} state_e;

  state_e         state_q, state_d;
  logic [INS-1:0] w_q, w_d;
  logic [SW-1:0]  s_q, s_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           bv;

  assign bv        = (state_q == RUN) && (cnt_q == CNT_DONE);
  assign bit_valid = bv;
  assign bit_last  = bv && (s_q == S_LAST);
  assign in_ready  = (state_q == IDLE);
  assign w_out     = w_q;
  assign s_out     = s_q;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          w_d     = in_data;
          s_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // flush outranks a bit accept landing on the same edge
        if (flush) begin
          state_d = IDLE;
          s_d     = '0;
          cnt_d   = '0;
        end else if (bv && bit_ready) begin
          cnt_d = '0;
          if (s_q == S_LAST) begin
            state_d = IDLE;
            s_d     = '0;
          end else begin
            s_d = s_q + SW'(1);
          end
        end else if (cnt_q != CNT_DONE) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed bench for mux_select_sequencer: a vector table on INS=4/SETTLE=0 plus
// hand sequences for settle timing, INS=5 select range and asynchronous reset.
module tb_mux_select_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: INS=4, SETTLE=0
  logic [3:0] d_a = '0, w_a;
  logic [1:0] s_a;
  logic iv_a = 1'b0, br_a = 1'b0, fl_a = 1'b0, rdy_a, bv_a, bl_a;
  // DUT B: INS=4, SETTLE=2
  logic [3:0] d_b = '0, w_b;
  logic [1:0] s_b;
  logic iv_b = 1'b0, br_b = 1'b0, fl_b = 1'b0, rdy_b, bv_b, bl_b;
  // DUT C: INS=5, SETTLE=0
  logic [4:0] d_c = '0, w_c;
  logic [2:0] s_c;
  logic iv_c = 1'b0, br_c = 1'b0, fl_c = 1'b0, rdy_c, bv_c, bl_c;

  mux_select_sequencer #(.INS(4), .SETTLE(0)) u_a (
    .clk(clk), .rst(rst), .in_data(d_a), .in_valid(iv_a), .in_ready(rdy_a),
    .flush(fl_a), .w_out(w_a), .s_out(s_a), .bit_valid(bv_a), .bit_last(bl_a),
    .bit_ready(br_a));
  mux_select_sequencer #(.INS(4), .SETTLE(2)) u_b (
    .clk(clk), .rst(rst), .in_data(d_b), .in_valid(iv_b), .in_ready(rdy_b),
    .flush(fl_b), .w_out(w_b), .s_out(s_b), .bit_valid(bv_b), .bit_last(bl_b),
    .bit_ready(br_b));
  mux_select_sequencer #(.INS(5), .SETTLE(0)) u_c (
    .clk(clk), .rst(rst), .in_data(d_c), .in_valid(iv_c), .in_ready(rdy_c),
    .flush(fl_c), .w_out(w_c), .s_out(s_c), .bit_valid(bv_c), .bit_last(bl_c),
    .bit_ready(br_c));

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic       iv;
    logic [3:0] d;
    logic       br;
    logic       fl;
    logic       rdy;
    logic [3:0] w;
    logic [1:0] s;
    logic       bv;
    logic       bl;
  } vec_t;

  vec_t vecs[33];

  function automatic vec_t mk(input logic iv, input logic [3:0] d, input logic br,
                              input logic fl, input logic rdy, input logic [3:0] w,
                              input logic [1:0] s, input logic bv, input logic bl);
    vec_t v;
    v.iv = iv; v.d = d; v.br = br; v.fl = fl;
    v.rdy = rdy; v.w = w; v.s = s; v.bv = bv; v.bl = bl;
    return v;
  endfunction

  initial begin
    logic [3:0] word_b;
    logic [4:0] word_c;
    // word 10, bit_ready high
    vecs[0]  = mk(1, 4'd10, 1, 0, 0, 4'd10, 2'd0, 1, 0);
    vecs[1]  = mk(0, 4'd0,  1, 0, 0, 4'd10, 2'd1, 1, 0);
    vecs[2]  = mk(0, 4'd0,  1, 0, 0, 4'd10, 2'd2, 1, 0);
    vecs[3]  = mk(0, 4'd0,  1, 0, 0, 4'd10, 2'd3, 1, 1);
    vecs[4]  = mk(0, 4'd0,  1, 0, 1, 4'd10, 2'd0, 0, 0);
    // word 6, backpressure for 5 cycles at s=1
    vecs[5]  = mk(1, 4'd6,  0, 0, 0, 4'd6, 2'd0, 1, 0);
    vecs[6]  = mk(0, 4'd0,  1, 0, 0, 4'd6, 2'd1, 1, 0);
    for (int i = 7; i <= 11; i++) vecs[i] = mk(0, 4'd0, 0, 0, 0, 4'd6, 2'd1, 1, 0);
    vecs[12] = mk(0, 4'd0,  1, 0, 0, 4'd6, 2'd2, 1, 0);
    vecs[13] = mk(0, 4'd0,  1, 0, 0, 4'd6, 2'd3, 1, 1);
    vecs[14] = mk(0, 4'd0,  1, 0, 1, 4'd6, 2'd0, 0, 0);
    // in_valid held high, data changes during RUN
    vecs[15] = mk(1, 4'd4,  1, 0, 0, 4'd4, 2'd0, 1, 0);
    vecs[16] = mk(1, 4'd10, 1, 0, 0, 4'd4, 2'd1, 1, 0);
    vecs[17] = mk(1, 4'd10, 1, 0, 0, 4'd4, 2'd2, 1, 0);
    vecs[18] = mk(1, 4'd10, 1, 0, 0, 4'd4, 2'd3, 1, 1);
    vecs[19] = mk(1, 4'd10, 1, 0, 1, 4'd4, 2'd0, 0, 0);
    vecs[20] = mk(1, 4'd10, 1, 0, 0, 4'd10, 2'd0, 1, 0);
    vecs[21] = mk(0, 4'd0,  1, 0, 0, 4'd10, 2'd1, 1, 0);
    vecs[22] = mk(0, 4'd0,  1, 0, 0, 4'd10, 2'd2, 1, 0);
    vecs[23] = mk(0, 4'd0,  1, 0, 0, 4'd10, 2'd3, 1, 1);
    vecs[24] = mk(0, 4'd0,  1, 0, 1, 4'd10, 2'd0, 0, 0);
    // flush at s=2 colliding with an accept; flush in IDLE blocks capture
    vecs[25] = mk(1, 4'd9,  1, 0, 0, 4'd9, 2'd0, 1, 0);
    vecs[26] = mk(0, 4'd0,  1, 0, 0, 4'd9, 2'd1, 1, 0);
    vecs[27] = mk(0, 4'd0,  1, 0, 0, 4'd9, 2'd2, 1, 0);
    vecs[28] = mk(0, 4'd0,  1, 1, 1, 4'd9, 2'd0, 0, 0);
    vecs[29] = mk(1, 4'd5,  0, 1, 1, 4'd9, 2'd0, 0, 0);
    vecs[30] = mk(1, 4'd5,  0, 0, 0, 4'd5, 2'd0, 1, 0);
    vecs[31] = mk(0, 4'd0,  0, 0, 0, 4'd5, 2'd0, 1, 0);
    vecs[32] = mk(0, 4'd0,  0, 1, 1, 4'd5, 2'd0, 0, 0);

    // reset state of all three instances
    #12;
    chk("reset_a", {23'd0, rdy_a, w_a, s_a, bv_a, bl_a}, {23'd0, 1'b1, 4'd0, 2'd0, 1'b0, 1'b0});
    chk("reset_b", {23'd0, rdy_b, w_b, s_b, bv_b, bl_b}, {23'd0, 1'b1, 4'd0, 2'd0, 1'b0, 1'b0});
    chk("reset_c", {21'd0, rdy_c, w_c, s_c, bv_c, bl_c}, {21'd0, 1'b1, 5'd0, 3'd0, 1'b0, 1'b0});
    rst = 1'b0;

    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      iv_a = vecs[i].iv; d_a = vecs[i].d; br_a = vecs[i].br; fl_a = vecs[i].fl;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), {23'd0, rdy_a, w_a, s_a, bv_a, bl_a},
          {23'd0, vecs[i].rdy, vecs[i].w, vecs[i].s, vecs[i].bv, vecs[i].bl});
    end
    @(negedge clk);
    iv_a = 1'b0; fl_a = 1'b0; br_a = 1'b0;

    // SETTLE=2: each select held 3 cycles, bit_valid only in the third
    word_b = 4'd2;
    @(negedge clk);
    iv_b = 1'b1; d_b = word_b; br_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 0) iv_b = 1'b0;
      chk($sformatf("settle%0d", i), {28'd0, s_b, bv_b, bl_b},
          {28'd0, 2'(i / 3), 1'(i % 3 == 2), 1'((i % 3 == 2) && (i / 3 == 3))});
      if (i % 3 == 2) chk($sformatf("settle_f%0d", i / 3), 32'(w_b[s_b]), 32'(word_b[i / 3]));
    end
    @(posedge clk); #1;
    chk("settle_end", {28'd0, rdy_b, s_b, bv_b}, {28'd0, 1'b1, 2'd0, 1'b0});
    @(negedge clk);
    br_b = 1'b0;

    // INS=5: select walks 0..4 then returns to 0 through IDLE
    word_c = 5'b10110;
    @(negedge clk);
    iv_c = 1'b1; d_c = word_c; br_c = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 0) iv_c = 1'b0;
      chk($sformatf("ins5_%0d", i), {21'd0, rdy_c, w_c, s_c, bv_c, bl_c},
          {21'd0, 1'b0, word_c, 3'(i), 1'b1, 1'(i == 4)});
    end
    @(posedge clk); #1;
    chk("ins5_idle", {21'd0, rdy_c, w_c, s_c, bv_c, bl_c},
        {21'd0, 1'b1, word_c, 3'd0, 1'b0, 1'b0});

    // asynchronous reset mid-word at s=3
    @(negedge clk);
    iv_c = 1'b1; d_c = 5'b01011;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      iv_c = 1'b0;
    end
    chk("pre_rst_s", 32'(s_c), 32'd3);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_c", {21'd0, rdy_c, w_c, s_c, bv_c, bl_c}, {21'd0, 1'b1, 5'd0, 3'd0, 1'b0, 1'b0});
    chk("async_rst_a_w", 32'(w_a), 32'd0);
    @(negedge clk);
    rst = 1'b0; br_c = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_c", {21'd0, rdy_c, w_c, s_c, bv_c, bl_c}, {21'd0, 1'b1, 5'd0, 3'd0, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
